// File: rtl/dawson_responder_if.sv
// dawson_responder_if: Dawson stb/ack responder wrapping a start/done two-operand core.
// Optional core watchdog enabled by defining DAWSON_RESP_TIMEOUT_EN.
module dawson_responder_if #(
    parameter int WIDTH          = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_b_stb,
    output logic             input_b_ack,
    output logic [WIDTH-1:0] output_z,
    output logic             output_z_stb,
    input  logic             output_z_ack,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic             core_start,
    input  logic [WIDTH-1:0] core_result,
    input  logic             core_done,
    output logic             busy,
    output logic             timeout_err
);
    typedef enum logic [2:0] {S_GET_A, S_GET_B, S_START, S_WAIT, S_PUT_Z} state_t;

    state_t           state_q, state_d;
    logic             a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
    logic             start_q, start_d, busy_q, busy_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;

`ifdef DAWSON_RESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          terr_q, terr_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end
    assign timeout_err = terr_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_ack_d = a_ack_q;
        b_ack_d = b_ack_q;
        z_stb_d = z_stb_q;
        start_d = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
`ifdef DAWSON_RESP_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = terr_q;
`endif
        case (state_q)
            S_GET_A: begin
                a_ack_d = 1'b1;
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                b_ack_d = 1'b1;
                if (b_ack_q && input_b_stb) begin
                    b_d     = input_b;
                    b_ack_d = 1'b0;
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef DAWSON_RESP_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (core_done) begin
                    z_d     = core_result;
                    z_stb_d = 1'b1;
                    state_d = S_PUT_Z;
                end
`ifdef DAWSON_RESP_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Core never answered: hand back a quiet NaN instead of hanging the initiator
                    z_d     = WIDTH'(64'h7FF8000000000000);
                    z_stb_d = 1'b1;
                    terr_d  = 1'b1;
                    state_d = S_PUT_Z;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_PUT_Z: begin
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = S_GET_A;
                end
            end
            default: state_d = S_GET_A;
        endcase
        busy_d = state_d != S_GET_A;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_GET_A;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            z_stb_q <= z_stb_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
        end
    end

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z_stb = z_stb_q;
    assign output_z     = z_q;
    assign core_a       = a_q;
    assign core_b       = b_q;
    assign core_start   = start_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_dawson_responder_if.sv
// tb_dawson_responder_if: directed and randomized operations through a stub FP-adder core,
// checked against a transaction-level model of the Dawson exchange.
module tb_dawson_responder_if;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] input_a = '0, input_b = '0;
    logic        input_a_stb = 1'b0, input_b_stb = 1'b0, output_z_ack = 1'b0;
    logic        input_a_ack, input_b_ack, output_z_stb;
    logic [63:0] output_z, core_a, core_b;
    logic        core_start, busy, timeout_err;
    logic [63:0] core_result = '0;
    logic        core_done = 1'b0;

    int n_chk = 0, n_fail = 0;
    int n_start = 0, exp_starts = 0;
    int core_lat = 4;
    int cd_cnt = 0;
    logic [63:0] ca = '0, cb = '0;

    dawson_responder_if dut (
        .clk(clk), .rst(rst),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
        .core_a(core_a), .core_b(core_b), .core_start(core_start),
        .core_result(core_result), .core_done(core_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Stub core: double-precision adder with programmable latency; 0 means it never answers
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start) n_start <= n_start + 1;
        if (core_start && core_lat > 0) begin
            cd_cnt <= core_lat;
            ca     <= core_a;
            cb     <= core_b;
        end else if (cd_cnt > 0) begin
            cd_cnt <= cd_cnt - 1;
            if (cd_cnt == 1) begin
                core_done   <= 1'b1;
                core_result <= $realtobits($bitstoreal(ca) + $bitstoreal(cb));
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int w);
        return w == 0 ? input_a_ack : w == 1 ? input_b_ack : output_z_stb;
    endfunction

    task automatic wait_hi(input int w, input int lim, input string tag);
        int n = 0;
        while (!sig(w) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(sig(w)), 64'd1);
    endtask

    task automatic send_a(input logic [63:0] a, input bit both);
        input_a     = a;
        input_a_stb = 1'b1;
        if (both) input_b_stb = 1'b1;
        wait_hi(0, 50, "a_ack_wait");
        @(negedge clk);
        input_a_stb = 1'b0;
        chk("core_a", core_a, a);
        chk("b_ack_first_cycle", 64'(input_b_ack), 64'd0);
    endtask

    task automatic send_b(input logic [63:0] b, input int dly);
        if (!input_b_stb) repeat (dly) @(negedge clk);
        chk("no_start_before_b", 64'(n_start), 64'(exp_starts));
        input_b     = b;
        input_b_stb = 1'b1;
        wait_hi(1, 50, "b_ack_wait");
        @(negedge clk);
        exp_starts++;
        chk("core_b", core_b, b);
        chk("start_pulse", 64'(core_start), 64'd1);
        if ($urandom_range(0, 1) == 0) input_b_stb = 1'b0;
        @(negedge clk);
        input_b_stb = 1'b0;
        chk("start_one_cycle", 64'(core_start), 64'd0);
    endtask

    task automatic recv_z(input logic [63:0] exp, input int zdly, input logic [63:0] a,
                          input logic [63:0] b);
        wait_hi(2, 3000, "z_stb_wait");
        chk("output_z", output_z, exp);
        chk("busy_in_put", 64'(busy), 64'd1);
        chk("core_a_held", core_a, a);
        chk("core_b_held", core_b, b);
        repeat (zdly) begin
            @(negedge clk);
            chk("z_stable", {output_z[62:0], output_z_stb}, {exp[62:0], 1'b1});
        end
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        chk("z_stb_drop", 64'(output_z_stb), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("z_kept", output_z, exp);
        chk("a_ack_late", 64'(input_a_ack), 64'd0);
        chk("start_count", 64'(n_start), 64'(exp_starts));
        @(negedge clk);
        chk("a_ack_next", 64'(input_a_ack), 64'd1);
    endtask

    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int bdly, input int zdly, input bit both);
        input_b = b;
        send_a(a, both);
        send_b(b, bdly);
        recv_z(exp, zdly, a, b);
    endtask

    function automatic logic [63:0] rnd_real();
        real r = real'(int'($urandom_range(0, 2000000)) - 1000000) / 1000.0;
        return $realtobits(r);
    endfunction

    initial begin
        logic [63:0] ra, rb;
        bit bad;
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", {input_a_ack, input_b_ack, output_z_stb, core_start, busy},
                64'd0);
            chk("rst_data", core_a | core_b | output_z, 64'd0);
        end
        rst = 1'b0;
        #1 chk("a_ack_before_edge", 64'(input_a_ack), 64'd0);
        @(negedge clk);
        chk("a_ack_after_rst", 64'(input_a_ack), 64'd1);
        chk("busy_after_rst", 64'(busy), 64'd0);

        core_lat = 4;
        do_op(64'h3FF3AE147AE147AE, 64'h40123D70A3D70A3D, 64'h401728F5C28F5C28, 0, 2, 0);
        do_op(64'h3FF3AE147AE147AE, 64'h40123D70A3D70A3D, 64'h401728F5C28F5C28, 10, 7, 0);

        core_lat = 1;
        do_op($realtobits(1973.48143), $realtobits(9218.4018), 64'h40C5DBF10DAE3E6C, 0, 0, 1);
        do_op($realtobits(49145.21), $realtobits(-28401.305), 64'h40D441F9EB851EB8, 0, 0, 0);
        do_op(64'd0, 64'd0, 64'd0, 0, 0, 1);

        core_lat = 12;
        input_b  = 64'h4000000000000000;
        send_a(64'h3FF0000000000000, 0);
        send_b(64'h4000000000000000, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("async_rst_outs", {input_a_ack, input_b_ack, output_z_stb, core_start, busy},
               64'd0);
        chk("async_rst_data", core_a | core_b | output_z, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (output_z_stb || busy || output_z != 64'd0) bad = 1'b1;
        end
        chk("late_done_ignored", 64'(bad), 64'd0);
        core_lat = 3;
        do_op($realtobits(2.5), $realtobits(0.25), $realtobits(2.75), 1, 1, 0);

        repeat (20) begin
            ra       = rnd_real();
            rb       = rnd_real();
            core_lat = int'($urandom_range(1, 6));
            do_op(ra, rb, $realtobits($bitstoreal(ra) + $bitstoreal(rb)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)));
        end

`ifdef DAWSON_RESP_TIMEOUT_EN
        core_lat = 0;
        input_b  = 64'h4000000000000000;
        send_a(64'h3FF0000000000000, 0);
        send_b(64'h4000000000000000, 0);
        recv_z(64'h7FF8000000000000, 1, 64'h3FF0000000000000, 64'h4000000000000000);
        chk("timeout_err_set", 64'(timeout_err), 64'd1);
        core_lat = 2;
        do_op($realtobits(1.0), $realtobits(1.0), $realtobits(2.0), 0, 0, 0);
        chk("timeout_err_sticky", 64'(timeout_err), 64'd1);
`else
        chk("timeout_err_zero", 64'(timeout_err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
